// File: rtl/aes_128_sched_if.sv
// Channel, core-side and result signals of the aes_128_sched scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface aes_128_sched_if;
    logic         ch0_valid;
    logic [127:0] ch0_data;
    logic         ch0_ready;
    logic         ch1_valid;
    logic [127:0] ch1_data;
    logic         ch1_ready;
    logic         aes_in_en;
    logic [127:0] aes_in_data;
    logic         aes_key_idx;
    logic         aes_out_en;
    logic [127:0] aes_out_data;
    logic         res0_en;
    logic [127:0] res0_data;
    logic         res1_en;
    logic [127:0] res1_data;
    logic [6:0]   inflight;
    logic         busy;
    logic         orphan_irq_pulse;
    logic         wdog_irq_pulse;

    modport slave (
        input  ch0_valid, ch0_data, ch1_valid, ch1_data,
        input  aes_out_en, aes_out_data,
        output ch0_ready, ch1_ready,
        output aes_in_en, aes_in_data, aes_key_idx,
        output res0_en, res0_data, res1_en, res1_data,
        output inflight, busy, orphan_irq_pulse, wdog_irq_pulse
    );

    modport master (
        output ch0_valid, ch0_data, ch1_valid, ch1_data,
        output aes_out_en, aes_out_data,
        input  ch0_ready, ch1_ready,
        input  aes_in_en, aes_in_data, aes_key_idx,
        input  res0_en, res0_data, res1_en, res1_data,
        input  inflight, busy, orphan_irq_pulse, wdog_irq_pulse
    );
endinterface

// File: rtl/aes_128_sched.sv
// Two-channel round-robin scheduler in front of a two-key aes_128_top core.
// Define AES_SCHED_WDOG_EN to build the in-flight watchdog.
module aes_128_sched #(
    parameter int MAX_INFLIGHT   = 16,
    parameter int MAX_BURST      = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic            clk,
    input logic            kill,
    aes_128_sched_if.slave bus
);
    localparam int AW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        burst, burst_nxt;
    logic              last;
    logic [MAX_INFLIGHT-1:0] tags;
    logic [AW-1:0]     wptr, rptr;
    logic [6:0]        cnt;
    logic              grant, sel, pop;
    logic              in_en, key_idx;
    logic [127:0]      in_data;
    logic              r0_en, r1_en, orphan;
    logic [127:0]      r0_data, r1_data;

    always_comb begin
        grant     = 1'b0;
        sel       = 1'b0;
        state_nxt = state;
        burst_nxt = burst;
        if (!kill && state != GAP && cnt < 7'(MAX_INFLIGHT) &&
            (bus.ch0_valid || bus.ch1_valid))
            grant = 1'b1;
        // On a tie the channel not served last wins
        if (bus.ch0_valid && bus.ch1_valid)
            sel = ~last;
        else
            sel = bus.ch1_valid;
        unique case (state)
            GAP: begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end
            default: begin
                if (grant) begin
                    burst_nxt = burst + 4'd1;
                    state_nxt = (burst_nxt >= 4'(MAX_BURST)) ? GAP : ISSUE;
                end else begin
                    burst_nxt = '0;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    assign pop = bus.aes_out_en && (cnt != 7'd0);

    always_ff @(posedge clk) begin
        if (kill) begin
            state   <= IDLE;
            burst   <= '0;
            last    <= 1'b1;
            tags    <= '0;
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            in_en   <= 1'b0;
            in_data <= '0;
            key_idx <= 1'b0;
            r0_en   <= 1'b0;
            r0_data <= '0;
            r1_en   <= 1'b0;
            r1_data <= '0;
            orphan  <= 1'b0;
        end else begin
            state  <= state_nxt;
            burst  <= burst_nxt;
            in_en  <= grant;
            r0_en  <= pop && !tags[rptr];
            r1_en  <= pop && tags[rptr];
            orphan <= bus.aes_out_en && (cnt == 7'd0);
            cnt    <= cnt + {6'd0, grant} - {6'd0, pop};
            if (grant) begin
                last       <= sel;
                in_data    <= sel ? bus.ch1_data : bus.ch0_data;
                key_idx    <= sel;
                tags[wptr] <= sel;
                wptr       <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
                if (tags[rptr])
                    r1_data <= bus.aes_out_data;
                else
                    r0_data <= bus.aes_out_data;
            end
        end
    end

    assign bus.ch0_ready        = grant && !sel;
    assign bus.ch1_ready        = grant && sel;
    assign bus.aes_in_en        = in_en;
    assign bus.aes_in_data      = in_data;
    assign bus.aes_key_idx      = key_idx;
    assign bus.res0_en          = r0_en;
    assign bus.res0_data        = r0_data;
    assign bus.res1_en          = r1_en;
    assign bus.res1_data        = r1_data;
    assign bus.inflight         = cnt;
    assign bus.busy             = (cnt != 7'd0) || in_en;
    assign bus.orphan_irq_pulse = orphan;

`ifdef AES_SCHED_WDOG_EN
    logic [31:0] wd;
    logic        wd_irq;

    always_ff @(posedge clk) begin
        if (kill || bus.aes_out_en || cnt == 7'd0) begin
            wd     <= '0;
            wd_irq <= 1'b0;
        end else if (wd + 32'd1 == 32'(TIMEOUT_CYCLES)) begin
            wd     <= '0;
            wd_irq <= 1'b1;
        end else begin
            wd     <= wd + 32'd1;
            wd_irq <= 1'b0;
        end
    end

    assign bus.wdog_irq_pulse = wd_irq;
`else
    assign bus.wdog_irq_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_aes_128_sched.sv
// Bench for aes_128_sched: a behavioural core with fixed latency plus
// issue/result scoreboards, a grant-pattern table and corner sequences.
`timescale 1ns/1ps
module tb_aes_128_sched;
    localparam int LAT = 5;
    localparam logic [127:0] PT0 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K0  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] K1  = 128'h123456789abcdef0fedcba9876543210;

    typedef struct {
        logic         ch;
        logic [127:0] data;
    } iss_t;
    typedef struct {
        int           due;
        logic [127:0] d;
    } core_t;
    typedef struct {
        bit v0, v1, r0, r1, en;
    } row_t;

    logic clk = 1'b0;
    logic kill = 1'b1;
    aes_128_sched_if bus();

    aes_128_sched #(
        .MAX_INFLIGHT(16),
        .MAX_BURST(3),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk),
        .kill(kill),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_hs, t0, got;
    logic s_rdy0, s_rdy1;
    bit core_hold, core_one, inj, orph_exp;
    iss_t cur;
    iss_t iss_q[$];
    core_t core_q[$];
    logic [127:0] exp0_q[$], exp1_q[$];
    int wd_t[$];
    row_t tbl[7];

    function automatic logic [127:0] core_f(logic [127:0] d, logic k);
        if (!k && d == PT0)
            return CT0;
        return d ^ (k ? K1 : K0);
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(string nm, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chki(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        #3;
        s_rdy0 = bus.ch0_ready;
        s_rdy1 = bus.ch1_ready;
        if (bus.ch0_valid && s_rdy0)
            iss_q.push_back('{1'b0, bus.ch0_data});
        if (bus.ch1_valid && s_rdy1)
            iss_q.push_back('{1'b1, bus.ch1_data});
        @(posedge clk);
        #1;
        cyc++;
        if (bus.aes_in_en) begin
            if (iss_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL issue: aes_in_en=1 with no accepted block");
            end else begin
                cur = iss_q.pop_front();
                chk1("issue_key", bus.aes_key_idx, cur.ch);
                chk("issue_data", bus.aes_in_data, cur.data);
                if (cur.ch)
                    exp1_q.push_back(core_f(cur.data, 1'b1));
                else
                    exp0_q.push_back(core_f(cur.data, 1'b0));
            end
            core_q.push_back('{cyc + LAT, core_f(bus.aes_in_data, bus.aes_key_idx)});
        end else if (iss_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL issue: accepted block not issued");
            iss_q.delete();
        end
        if (bus.res0_en) begin
            if (exp0_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL res0: unexpected res0_en data=%h", bus.res0_data);
            end else
                chk("res0_data", bus.res0_data, exp0_q.pop_front());
        end
        if (bus.res1_en) begin
            if (exp1_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL res1: unexpected res1_en data=%h", bus.res1_data);
            end else
                chk("res1_data", bus.res1_data, exp1_q.pop_front());
        end
        if (bus.orphan_irq_pulse && !orph_exp) begin
            total++;
            bad++;
            $display("FAIL orphan: got 1 want 0");
        end
        if (bus.wdog_irq_pulse)
            wd_t.push_back(cyc);
        bus.aes_out_en   = 1'b0;
        bus.aes_out_data = '0;
        if (inj) begin
            bus.aes_out_en   = 1'b1;
            bus.aes_out_data = 128'hdeadbeef_00000000_cafef00d_12345678;
            inj = 1'b0;
        end else if (core_q.size() != 0 && core_q[0].due <= cyc &&
                     (!core_hold || core_one)) begin
            bus.aes_out_en   = 1'b1;
            bus.aes_out_data = core_q[0].d;
            void'(core_q.pop_front());
            core_one = 1'b0;
        end
    endtask

    task automatic do_kill();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        iss_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        core_q.delete();
        bus.aes_out_en = 1'b0;
        core_hold = 1'b0;
    endtask

    task automatic drain(string nm);
        for (int i = 0; i < 200; i++) begin
            if (exp0_q.size() == 0 && exp1_q.size() == 0 && core_q.size() == 0)
                break;
            tick();
        end
        tick();
        chki(nm, exp0_q.size() + exp1_q.size(), 0);
        chki({nm, "_inflight"}, int'(bus.inflight), 0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        tbl[0] = '{1, 1, 1, 0, 1};
        tbl[1] = '{1, 1, 0, 1, 1};
        tbl[2] = '{1, 1, 1, 0, 1};
        tbl[3] = '{1, 1, 0, 0, 0};
        tbl[4] = '{1, 1, 0, 1, 1};
        tbl[5] = '{1, 1, 1, 0, 1};
        tbl[6] = '{1, 1, 0, 1, 1};

        bus.ch0_valid    = 1'b0;
        bus.ch0_data     = '0;
        bus.ch1_valid    = 1'b0;
        bus.ch1_data     = '0;
        bus.aes_out_en   = 1'b0;
        bus.aes_out_data = '0;
        core_hold = 1'b0;
        core_one  = 1'b0;
        inj       = 1'b0;
        orph_exp  = 1'b0;
        kill      = 1'b1;

        // Reset state, readies held low while kill is high
        tick();
        bus.ch0_valid = 1'b1;
        bus.ch1_valid = 1'b1;
        tick();
        chk1("rst_ready0", s_rdy0, 1'b0);
        chk1("rst_ready1", s_rdy1, 1'b0);
        chk1("rst_in_en", bus.aes_in_en, 1'b0);
        chk("rst_in_data", bus.aes_in_data, '0);
        chki("rst_inflight", int'(bus.inflight), 0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_res0_en", bus.res0_en, 1'b0);
        chk1("rst_res1_en", bus.res1_en, 1'b0);
        chk1("rst_orphan", bus.orphan_irq_pulse, 1'b0);
        bus.ch0_valid = 1'b0;
        bus.ch1_valid = 1'b0;
        kill = 1'b0;

        // Single block on channel 0
        bus.ch0_valid = 1'b1;
        bus.ch0_data  = PT0;
        tick();
        bus.ch0_valid = 1'b0;
        chk1("t1_ready", s_rdy0, 1'b1);
        chk1("t1_in_en", bus.aes_in_en, 1'b1);
        chk1("t1_key", bus.aes_key_idx, 1'b0);
        chki("t1_inflight", int'(bus.inflight), 1);
        t0 = cyc;
        got = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.res0_en) begin
                got = cyc;
                break;
            end
        end
        chki("t1_latency", got - t0, LAT + 1);
        chk("t1_res0", bus.res0_data, CT0);
        chki("t1_inflight_end", int'(bus.inflight), 0);
        tick();
        chk1("t1_busy_end", bus.busy, 1'b0);

        // Both channels requesting: round robin with a forced gap
        do_kill();
        for (int i = 0; i < 7; i++) begin
            bus.ch0_valid = tbl[i].v0;
            bus.ch1_valid = tbl[i].v1;
            bus.ch0_data  = rnd128();
            bus.ch1_data  = rnd128();
            tick();
            chk1($sformatf("rr_ready0[%0d]", i), s_rdy0, tbl[i].r0);
            chk1($sformatf("rr_ready1[%0d]", i), s_rdy1, tbl[i].r1);
            chk1($sformatf("rr_in_en[%0d]", i), bus.aes_in_en, tbl[i].en);
        end
        bus.ch0_valid = 1'b0;
        bus.ch1_valid = 1'b0;
        drain("rr_drain");

        // Fill to the in-flight limit with results withheld
        core_hold = 1'b1;
        n_hs = 0;
        bus.ch0_valid = 1'b1;
        bus.ch1_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.ch0_data = rnd128();
            bus.ch1_data = rnd128();
            tick();
            n_hs += int'(s_rdy0) + int'(s_rdy1);
        end
        chki("full_issues", n_hs, 16);
        chki("full_inflight", int'(bus.inflight), 16);
        chk1("full_ready0", s_rdy0, 1'b0);
        chk1("full_ready1", s_rdy1, 1'b0);
        core_one = 1'b1;
        tick();
        chk1("full_hold_a", s_rdy0 | s_rdy1, 1'b0);
        tick();
        chk1("full_hold_b", s_rdy0 | s_rdy1, 1'b0);
        chki("full_pop", int'(bus.inflight), 15);
        bus.ch0_data = rnd128();
        bus.ch1_data = rnd128();
        tick();
        chki("full_regrant", int'(s_rdy0) + int'(s_rdy1), 1);
        tick();
        chki("full_refull", int'(s_rdy0) + int'(s_rdy1), 0);
        chki("full_inflight2", int'(bus.inflight), 16);
        bus.ch0_valid = 1'b0;
        bus.ch1_valid = 1'b0;
        core_hold = 1'b0;
        drain("full_drain");

        // Core result with nothing outstanding
        do_kill();
        inj = 1'b1;
        tick();
        orph_exp = 1'b1;
        tick();
        chk1("orphan_pulse", bus.orphan_irq_pulse, 1'b1);
        chk1("orphan_res0", bus.res0_en, 1'b0);
        chk1("orphan_res1", bus.res1_en, 1'b0);
        orph_exp = 1'b0;
        tick();
        chk1("orphan_once", bus.orphan_irq_pulse, 1'b0);

        // kill in the middle of a burst, last grant on channel 0
        bus.ch1_valid = 1'b1;
        bus.ch1_data  = rnd128();
        tick();
        bus.ch1_valid = 1'b0;
        bus.ch0_valid = 1'b1;
        bus.ch0_data  = rnd128();
        tick();
        chk1("mid_pre_en", bus.aes_in_en, 1'b1);
        bus.ch1_valid = 1'b1;
        kill = 1'b1;
        tick();
        chk1("mid_ready0", s_rdy0, 1'b0);
        chk1("mid_ready1", s_rdy1, 1'b0);
        chk1("mid_in_en", bus.aes_in_en, 1'b0);
        chk("mid_in_data", bus.aes_in_data, '0);
        chk1("mid_key", bus.aes_key_idx, 1'b0);
        chk1("mid_res0_en", bus.res0_en, 1'b0);
        chk("mid_res0_data", bus.res0_data, '0);
        chk1("mid_res1_en", bus.res1_en, 1'b0);
        chk("mid_res1_data", bus.res1_data, '0);
        chki("mid_inflight", int'(bus.inflight), 0);
        chk1("mid_busy", bus.busy, 1'b0);
        kill = 1'b0;
        iss_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        core_q.delete();
        bus.aes_out_en = 1'b0;
        bus.ch0_data = rnd128();
        bus.ch1_data = rnd128();
        tick();
        chk1("mid_first0", s_rdy0, 1'b1);
        chk1("mid_first1", s_rdy1, 1'b0);
        bus.ch0_valid = 1'b0;
        bus.ch1_valid = 1'b0;
        drain("mid_drain");

`ifdef AES_SCHED_WDOG_EN
        do_kill();
        wd_t.delete();
        core_hold = 1'b1;
        bus.ch0_valid = 1'b1;
        bus.ch0_data  = rnd128();
        tick();
        bus.ch0_valid = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 2100; i++)
            tick();
        chki("wdog_count", wd_t.size(), 2);
        if (wd_t.size() >= 2) begin
            chki("wdog_first", wd_t[0] - t0, 1024);
            chki("wdog_second", wd_t[1] - t0, 2048);
        end
        core_hold = 1'b0;
        drain("wdog_drain");
`else
        chki("wdog_absent", wd_t.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
